alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sequencing stage wrapped around the 16-bit combinational ALU (opc/ina/inb/inc -> w/zer/neg).
- Accepts one operation per valid/ready handshake and reads operands from a small register file.
- Drives the ALU from registered operands, captures w/zer/neg one cycle later and writes the result back.
- Presents the result and sticky flags downstream over a second valid/ready handshake. One operation in flight at a time.

Parameters:
- DW, 16, datapath width; must equal ALU width (16).
- NREG, 4, register-file entries; index width $clog2(NREG) (2 at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  controller can accept an operation.
- in_opc  in  3  ALU opcode 000..110; 111 = LDI (load immediate, ALU bypassed).
- in_dst  in  2  destination register.
- in_sa  in  2  source register for ina.
- in_sb  in  2  source register for inb.
- in_cin_mode  in  2  inc source: 00=0, 01=1, 10=cf, 11=0.
- in_imm  in  DW  immediate for LDI.
- alu_opc  out  3  to ALU opc.
- alu_ina  out  DW  to ALU ina.
- alu_inb  out  DW  to ALU inb.
- alu_inc  out  1  to ALU inc.
- alu_w  in  DW  from ALU w.
- alu_zer  in  1  from ALU zer.
- alu_neg  in  1  from ALU neg.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  DW  result value.
- out_dst  out  2  register written.
- zf, nf, cf  out  1 each  sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; all register-file entries are cleared to 0.
  - alu_opc, alu_ina, alu_inb and alu_inc are 0; out_valid, out_data, out_dst, zf, nf and cf are 0.
  - in_ready is forced 0 while rst_n is low.
- States are IDLE, EXEC and RESP. in_ready = (state==IDLE) && rst_n.
- IDLE, when in_valid && in_ready and opc != 111:
  - Register alu_opc = in_opc, alu_ina = rf[in_sa], alu_inb = rf[in_sb], and alu_inc per in_cin_mode.
  - Latch in_dst, then go to EXEC.
- IDLE, when in_valid && in_ready and opc == 111 (LDI):
  - Write rf[in_dst] = in_imm; out_data = in_imm.
  - zf = (in_imm == 0), nf = in_imm[15]; cf unchanged. Go to RESP.
- EXEC (exactly 1 cycle; the ALU settles combinationally):
  - At the end of the cycle: rf[dst] = alu_w, out_data = alu_w, zf = alu_zer, nf = alu_neg.
  - cf is computed locally from the registered operands:
    - opc 010: bit 16 of the 17-bit unsigned sum ina + inb + inc.
    - opc 001: cf = (ina == 16'hFFFF).
    - All other opcodes: cf holds.
  - Go to RESP.
- RESP:
  - out_valid = 1; out_data and out_dst stay stable until accepted.
  - On out_ready, out_valid drops next cycle and the state returns to IDLE.
- Latency and throughput:
  - ALU op: handshake to out_valid is 2 cycles. LDI: 1 cycle.
  - Minimum initiation interval is 3 cycles for ALU ops and 2 for LDI.
- alu_* outputs hold their last values outside EXEC. No new operand is driven while in RESP.
- Register reads take values after all prior writebacks; there is no hazard because only one op is outstanding.
- in_sa == in_sb is legal; in_dst may equal a source (read happens in IDLE, write at the end of EXEC).
- A reset asserted mid-EXEC or mid-RESP abandons the operation: no writeback and no out_valid.
- Opcode 110 (byte concat) and 100/101 update zf/nf from the ALU like any other opcode.

Optional Feature:
- CARRY_CHAIN_EN defined:
  - in_cin_mode 10 selects cf, and cf is computed as above.
  - Allows multi-word adds by chaining consecutive 010 ops.
- CARRY_CHAIN_EN undefined:
  - cf is tied 0 and no carry logic is generated.
  - in_cin_mode 10 behaves as 00.

Test Plan:
- Load and signed overflow: LDI r1=16'h7FFF, LDI r2=16'h0001, then op 010 r3=r1+r2 with cin_mode 00.
  - Requires out_data=16'h8000, nf=1, zf=0, cf=0, out_dst=3, and out_valid exactly 2 cycles after the handshake.
- Carry chain (CARRY_CHAIN_EN defined):
  - LDI r0=16'hFFFF, then 010 r0+r2 with cin_mode 00 -> 16'h0000, zf=1, cf=1.
  - Next, 010 r2+r2 with cin_mode 10 -> 16'h0003, cf=0.
  - With the macro undefined, the second result must be 16'h0002.
- Arithmetic shift path: LDI r1=16'h0010, LDI r2=16'h8000, then op 011 r3=r1,r2.
  - Requires out_data=16'hC010, nf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - out_data and out_dst must stay stable, in_ready must stay 0, and a pending in_valid must be ignored.
  - The op is accepted on the first IDLE cycle after out_ready goes high.
- Reset mid-op: issue 010 r3=r1+r2, then pull rst_n low during EXEC.
  - All outputs go to 0 immediately, r3 reads 0 afterwards, and no out_valid appears.
- Unused opcode: op 111 via LDI with in_imm=16'h0000.
  - Requires zf=1, nf=0, cf unchanged, and the alu_* outputs unchanged.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer around a 16-bit combinational ALU.
// Define CARRY_CHAIN_EN to enable the carry flag and cf carry-in chaining.
module alu_issue_ctrl #(
  parameter  int DW   = 16,
  parameter  int NREG = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_opc,
  input  logic [AW-1:0] in_dst,
  input  logic [AW-1:0] in_sa,
  input  logic [AW-1:0] in_sb,
  input  logic [1:0]    in_cin_mode,
  input  logic [DW-1:0] in_imm,
  output logic [2:0]    alu_opc,
  output logic [DW-1:0] alu_ina,
  output logic [DW-1:0] alu_inb,
  output logic          alu_inc,
  input  logic [DW-1:0] alu_w,
  input  logic          alu_zer,
  input  logic          alu_neg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_dst,
  output logic          zf,
  output logic          nf,
  output logic          cf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rf_q [NREG];
  logic [AW-1:0] dst_q;
  logic [2:0]    opc_q;
  logic [DW-1:0] ina_q, inb_q;
  logic          inc_q, inc_d;
  logic [DW-1:0] data_q;
  logic          zf_q, nf_q;
  logic          accept, is_ldi;

  assign in_ready = (state_q == IDLE) && rst_n;
  assign accept   = in_valid && in_ready;
  assign is_ldi   = (in_opc == 3'b111);

`ifdef CARRY_CHAIN_EN
  logic          cf_q;
  logic [DW:0]   sum;
  logic          cy;

  // Carry out is any sum beyond the DW-bit range.
  assign sum = {1'b0, ina_q} + {1'b0, inb_q} + {{DW{1'b0}}, inc_q};
  assign cy  = (sum > {1'b0, {DW{1'b1}}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
    end else if (state_q == EXEC) begin
      if (opc_q == 3'b010) begin
        cf_q <= cy;
      end else if (opc_q == 3'b001) begin
        cf_q <= (ina_q == {DW{1'b1}});
      end
    end
  end

  assign cf = cf_q;
`else
  assign cf = 1'b0;
`endif

  always_comb begin
    inc_d = 1'b0;
    unique case (in_cin_mode)
      2'b01:   inc_d = 1'b1;
`ifdef CARRY_CHAIN_EN
      2'b10:   inc_d = cf_q;
`endif
      default: inc_d = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = is_ldi ? RESP : EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      dst_q  <= '0;
      opc_q  <= '0;
      ina_q  <= '0;
      inb_q  <= '0;
      inc_q  <= 1'b0;
      data_q <= '0;
      zf_q   <= 1'b0;
      nf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dst_q <= in_dst;
            if (is_ldi) begin
              rf_q[in_dst] <= in_imm;
              data_q       <= in_imm;
              zf_q         <= (in_imm == '0);
              nf_q         <= in_imm[DW-1];
            end else begin
              opc_q <= in_opc;
              ina_q <= rf_q[in_sa];
              inb_q <= rf_q[in_sb];
              inc_q <= inc_d;
            end
          end
        end
        EXEC: begin
          rf_q[dst_q] <= alu_w;
          data_q      <= alu_w;
          zf_q        <= alu_zer;
          nf_q        <= alu_neg;
        end
        default: ;
      endcase
    end
  end

  assign alu_opc   = opc_q;
  assign alu_ina   = ina_q;
  assign alu_inb   = inb_q;
  assign alu_inc   = inc_q;
  assign out_valid = (state_q == RESP);
  assign out_data  = data_q;
  assign out_dst   = dst_q;
  assign zf        = zf_q;
  assign nf        = nf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and register model.
// Honours CARRY_CHAIN_EN the same way as the design.
module tb_alu_issue_ctrl;

`ifdef CARRY_CHAIN_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opc = '0;
  logic [1:0]  in_dst = '0, in_sa = '0, in_sb = '0, in_cin_mode = '0;
  logic [15:0] in_imm = '0;
  logic [2:0]  alu_opc;
  logic [15:0] alu_ina, alu_inb, alu_w;
  logic        alu_inc, alu_zer, alu_neg;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_dst;
  logic        zf, nf, cf;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_dst(in_dst), .in_sa(in_sa), .in_sb(in_sb),
    .in_cin_mode(in_cin_mode), .in_imm(in_imm),
    .alu_opc(alu_opc), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc),
    .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst(out_dst),
    .zf(zf), .nf(nf), .cf(cf)
  );

  // Behavioural ALU: the environment the controller drives.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    logic [15:0] t;
    case (op)
      3'd0: t = a & b;
      3'd1: t = a + 16'd1;
      3'd2: t = a + b + {15'd0, c};
      3'd3: t = {b[15], b[15:1]} | a;
      3'd4: t = a ^ b;
      3'd5: t = a - b;
      3'd6: t = {a[7:0], b[7:0]};
      default: t = a | b;
    endcase
    return t;
  endfunction

  always_comb begin
    alu_w   = alu_fn(alu_opc, alu_ina, alu_inb, alu_inc);
    alu_zer = (alu_w == 16'd0);
    alu_neg = alu_w[15];
  end

  typedef struct {
    logic [15:0] data;
    logic [1:0]  dst;
    logic        zf, nf, cf;
    int          hs, lat;
  } exp_t;

  exp_t        exq[$];
  logic [15:0] m_rf [4];
  logic        m_cf;
  int          n_chk = 0, n_fail = 0;
  int          cyc = 0, last_pop = -1, bp_cnt = 0;
  bit          rnd_rdy = 1'b0;
  logic [15:0] last_data;
  logic [1:0]  last_dst;
  logic        last_zf, last_nf, last_cf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 16'd0;
    m_cf = 1'b0;
    last_pop = -1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] cm, input logic [15:0] imm,
                       input bit want_resp);
    exp_t        e;
    int          waits;
    bit          waited;
    logic [15:0] a, b, r;
    logic        c;
    int unsigned s;
    in_opc = op; in_dst = dst; in_sa = sa; in_sb = sb;
    in_cin_mode = cm; in_imm = imm; in_valid = 1'b1;
    waits = 0; waited = 1'b0;
    @(negedge clk);
    while (!in_ready) begin
      waited = 1'b1;
      waits++;
      if (waits > 100) begin
        chk("accept_timeout", 32'(waits), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.hs = cyc;
    if (waited && last_pop >= 0) chk("accept_first_idle", 32'(cyc), 32'(last_pop + 1));
    if (op == 3'b111) begin
      r = imm;
      e.lat = 1;
    end else begin
      a = m_rf[sa];
      b = m_rf[sb];
      c = (cm == 2'b01) || (cm == 2'b10 && CC && m_cf);
      r = alu_fn(op, a, b, c);
      if (CC && op == 3'b010) begin
        s = 32'(a) + 32'(b) + 32'(c);
        m_cf = (s > 32'd65535);
      end else if (CC && op == 3'b001) begin
        m_cf = (a == 16'hFFFF);
      end
      e.lat = 2;
    end
    m_rf[dst] = r;
    e.data = r; e.dst = dst; e.zf = (r == 16'd0); e.nf = r[15]; e.cf = m_cf;
    if (want_resp) exq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((exq.size() != 0 || out_valid) && n < 200);
    chk("drain_pending", 32'(exq.size()), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_dst"}, 32'(out_dst), 32'd0);
    chk({tag, "_flags"}, 32'({zf, nf, cf}), 32'd0);
    chk({tag, "_alu_opc"}, 32'(alu_opc), 32'd0);
    chk({tag, "_alu_ops"}, {alu_ina, alu_inb}, 32'd0);
    chk({tag, "_alu_inc"}, 32'(alu_inc), 32'd0);
  endtask

  // Monitor: latency, stability under backpressure and response contents.
  initial begin : monitor
    exp_t        e;
    bit          prev_v;
    logic [15:0] held_d;
    logic [1:0]  held_dst;
    prev_v = 1'b0; held_d = '0; held_dst = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (exq.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          else chk("latency", 32'(cyc - exq[0].hs), 32'(exq[0].lat));
          held_d = out_data; held_dst = out_dst;
        end else if (out_valid) begin
          chk("stall_data_stable", 32'(out_data), 32'(held_d));
          chk("stall_dst_stable", 32'(out_dst), 32'(held_dst));
        end
        if (out_valid) chk("in_ready_low_in_resp", 32'(in_ready), 32'd0);
        if (out_valid && out_ready && exq.size() != 0) begin
          e = exq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_dst", 32'(out_dst), 32'(e.dst));
          chk("zf", 32'(zf), 32'(e.zf));
          chk("nf", 32'(nf), 32'(e.nf));
          chk("cf", 32'(cf), 32'(e.cf));
          last_data = out_data; last_dst = out_dst;
          last_zf = zf; last_nf = nf; last_cf = cf;
          last_pop = cyc;
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (bp_cnt > 0) begin
        out_ready = 1'b0;
        if (out_valid) bp_cnt--;
      end else begin
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin : main
    logic [2:0]  op;
    logic [15:0] imm;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Signed overflow through the adder
    issue(3'b111, 2'd1, 2'd0, 2'd0, 2'b00, 16'h7FFF, 1'b1);
    issue(3'b111, 2'd2, 2'd0, 2'd0, 2'b00, 16'h0001, 1'b1);
    issue(3'b010, 2'd3, 2'd1, 2'd2, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("ovf_data", 32'(last_data), 32'h8000);
    chk("ovf_flags_zncf", 32'({last_zf, last_nf, last_cf}), 32'b010);
    chk("ovf_dst", 32'(last_dst), 32'd3);

    // Carry chain
    issue(3'b111, 2'd0, 2'd0, 2'd0, 2'b00, 16'hFFFF, 1'b1);
    issue(3'b010, 2'd0, 2'd0, 2'd2, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("chain_lo_data", 32'(last_data), 32'h0000);
    chk("chain_lo_zf", 32'(last_zf), 32'd1);
    chk("chain_lo_cf", 32'(last_cf), CC ? 32'd1 : 32'd0);
    issue(3'b010, 2'd3, 2'd2, 2'd2, 2'b10, 16'h0000, 1'b1);
    drain();
    chk("chain_hi_data", 32'(last_data), CC ? 32'h0003 : 32'h0002);
    chk("chain_hi_cf", 32'(last_cf), 32'd0);

    // Arithmetic shift path
    issue(3'b111, 2'd1, 2'd0, 2'd0, 2'b00, 16'h0010, 1'b1);
    issue(3'b111, 2'd2, 2'd0, 2'd0, 2'b00, 16'h8000, 1'b1);
    issue(3'b011, 2'd3, 2'd1, 2'd2, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("asr_data", 32'(last_data), 32'hC010);
    chk("asr_nf", 32'(last_nf), 32'd1);

    // Backpressure with a pending request behind it
    bp_cnt = 5;
    issue(3'b111, 2'd1, 2'd0, 2'd0, 2'b00, 16'h1234, 1'b1);
    issue(3'b100, 2'd2, 2'd1, 2'd3, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("bp_second_data", 32'(last_data), 32'(16'h1234 ^ 16'hC010));

    // Reset during EXEC abandons the op
    issue(3'b111, 2'd1, 2'd0, 2'd0, 2'b00, 16'h0005, 1'b1);
    issue(3'b111, 2'd2, 2'd0, 2'd0, 2'b00, 16'h0006, 1'b1);
    drain();
    issue(3'b010, 2'd3, 2'd1, 2'd2, 2'b00, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("midop_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_valid_after_abort", 32'(out_valid), 32'd0);
    issue(3'b010, 2'd1, 2'd3, 2'd3, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("r3_cleared", 32'(last_data), 32'd0);

    // LDI of zero leaves cf and the ALU operands untouched
    issue(3'b111, 2'd0, 2'd0, 2'd0, 2'b00, 16'hFFFF, 1'b1);
    issue(3'b001, 2'd1, 2'd0, 2'd0, 2'b01, 16'h0000, 1'b1);
    issue(3'b111, 2'd2, 2'd0, 2'd0, 2'b00, 16'h0000, 1'b1);
    drain();
    chk("ldi0_zf_nf", 32'({last_zf, last_nf}), 32'b10);
    chk("ldi0_cf_held", 32'(last_cf), CC ? 32'd1 : 32'd0);
    chk("ldi0_alu_opc", 32'(alu_opc), 32'd1);
    chk("ldi0_alu_ops", {alu_ina, alu_inb}, 32'hFFFF_FFFF);
    chk("ldi0_alu_inc", 32'(alu_inc), 32'd1);

    // Random traffic with random consumer stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = 16'h0000;
        1: imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      issue(op, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), imm, 1'b1);
    end
    drain();
    rnd_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
